// File: rtl/tx_arbiter.sv
// tx_arbiter
// Round-robin, packet-locked arbiter sharing one UART transmit byte channel
// among N requesters. When a requester is granted, it keeps the channel until its last
// byte is accepted or until MAX_BURST bytes have been sent. Backpressure from
// the transmit FIFO passes straight through to the granted requester.
//
// Optional build macro: TX_ARB_CHAN_TAG_EN. When defined, every grant starts
// with a tag byte {4'hA, g[3:0]} before the payload. The tag byte does not
// count toward MAX_BURST.
//
// Handshake: a byte moves on a posedge where out_vld && out_rdy. On the
// requester side, the same transfer is req_vld[g] && req_rdy[g]. Neither
// valid waits on ready; ready may be asserted while valid is low.
//
// Ports:
//   clk        in   system clock, posedge
//   rst        in   asynchronous active-low reset
//   req_vld    in   [N]   per-requester byte valid
//   req_data   in   [8N]  per-requester byte, lane i = [8i+7:8i]
//   req_last   in   [N]   current byte ends the packet
//   req_rdy    out  [N]   per-requester accept (at most one bit set)
//   out_data   out  [8]   byte to the transmit controller
//   out_vld    out        out_data valid
//   out_rdy    in         transmit FIFO not full
//   grant      out  [N]   one-hot owner, 0 when idle
//   busy       out        FSM not in IDLE
//   forced_rel out        one-cycle pulse after a MAX_BURST release
//   state_dbg  out  [2]   FSM state encoding, for observation
module tx_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_vld,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_rdy,
  output logic [7:0]       out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [N-1:0]     grant,
  output logic             busy,
  output logic             forced_rel,
  output logic [1:0]       state_dbg
);

  localparam int PTR_W = $clog2(N);
  localparam int SW    = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef TX_ARB_CHAN_TAG_EN
    S_TAG  = 2'd1,
`endif
    S_XFER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   g_q, g_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               forced_q, forced_d;

  // Round-robin scan: first valid requester at or after ptr, wrapping.
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [SW-1:0]      scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, ptr_q} + SW'(k);
      if (scan_idx >= SW'(N)) scan_idx = scan_idx - SW'(N);
      if (!win_found && req_vld[scan_idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Lane of the current owner.
  logic               sel_vld;
  logic               sel_last;
  logic [7:0]         sel_data;

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (g_q == PTR_W'(i)) begin
        sel_vld  = req_vld[i];
        sel_last = req_last[i];
        sel_data = req_data[8*i +: 8];
      end
    end
  end

`ifdef TX_ARB_CHAN_TAG_EN
  logic [3:0] tag_id;
  assign tag_id = 4'(g_q);
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    g_d      = g_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    forced_d = 1'b0;
    out_data = '0;
    out_vld  = 1'b0;
    req_rdy  = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          g_d              = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          cnt_d            = '0;
`ifdef TX_ARB_CHAN_TAG_EN
          state_d          = S_TAG;
`else
          state_d          = S_XFER;
`endif
        end
      end
`ifdef TX_ARB_CHAN_TAG_EN
      S_TAG: begin
        out_data = {4'hA, tag_id};
        out_vld  = 1'b1;
        if (out_rdy) state_d = S_XFER;
      end
`endif
      S_XFER: begin
        out_data = sel_data;
        out_vld  = sel_vld;
        // grant_q is one-hot on g, so this gates ready to the owner only.
        req_rdy  = grant_q & {N{out_rdy}};
        if (sel_vld && out_rdy) begin
          cnt_d = cnt_q + 8'd1;
          if (sel_last || (cnt_q + 8'd1 == 8'(MAX_BURST))) begin
            state_d  = S_IDLE;
            grant_d  = '0;
            // A last byte landing exactly on the limit is a normal release.
            forced_d = !sel_last;
            if (g_q == PTR_W'(N-1)) ptr_d = '0;
            else                    ptr_d = g_q + PTR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      g_q      <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      g_q      <= g_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      forced_q <= forced_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = (state_q != S_IDLE);
  assign forced_rel = forced_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: N=4, MAX_BURST=4. A packet-level reference model
// (owner index, pointer, sent count) predicts all outputs every cycle.
// Directed scenarios pin the expected streams and grant orders as literals.
module tb_tx_arbiter;
  localparam int N    = 4;
  localparam int MAXB = 4;
`ifdef TX_ARB_CHAN_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_vld;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_rdy;
  logic [7:0]     out_data;
  logic           out_vld;
  logic           out_rdy;
  logic [N-1:0]   grant;
  logic           busy;
  logic           forced_rel;
  logic [1:0]     state_dbg;

  tx_arbiter #(.N(N), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
    .req_last(req_last), .req_rdy(req_rdy), .out_data(out_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .grant(grant), .busy(busy),
    .forced_rel(forced_rel), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bookkeeping
  int           n_checks;
  int           n_err;
  logic [7:0]   src_d[N][$];
  logic         src_l[N][$];
  logic         en[N];
  logic         rdy_drive;
  logic [N-1:0] acc_mask;
  logic [7:0]   got_q[$];
  logic [7:0]   pay_q[$];
  logic [7:0]   exp_q[$];
  int           grant_log[$];
  int           forced_cnt;
  logic [N-1:0] prev_grant;

  // reference model
  int   m_owner;
  int   m_ptr;
  int   m_sent;
  logic m_tag;
  logic m_forced;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // driver tasks
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_vld[i]         = en[i] && (src_d[i].size() > 0);
      req_data[8*i +: 8] = (src_d[i].size() > 0) ? src_d[i][0] : 8'h00;
      req_last[i]        = (src_l[i].size() > 0) ? src_l[i][0] : 1'b0;
    end
    out_rdy = rdy_drive;
  endtask

  task automatic push_byte(int r, logic [7:0] b, logic l);
    src_d[r].push_back(b);
    src_l[r].push_back(l);
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_d[i].delete();
      src_l[i].delete();
    end
  endtask

  function automatic bit src_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (src_d[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Compare process: model prediction vs DUT outputs, then model update.
  task automatic monitor_cycle();
    logic [7:0]   e_data;
    logic         e_vld;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_grant;
    logic         e_busy;
    bit           found;
    if (!rst) begin
      m_owner  = -1;
      m_ptr    = 0;
      m_sent   = 0;
      m_tag    = 1'b0;
      m_forced = 1'b0;
    end
    e_data = 8'h00; e_vld = 1'b0; e_rdy = '0; e_grant = '0; e_busy = 1'b0;
    if (m_owner >= 0) begin
      e_busy  = 1'b1;
      e_grant = N'(1) << m_owner;
      if (m_tag) begin
        e_vld  = 1'b1;
        e_data = 8'hA0 | 8'(m_owner);
      end else begin
        e_vld  = req_vld[m_owner];
        e_data = req_data[8*m_owner +: 8];
        e_rdy  = out_rdy ? e_grant : '0;
      end
    end
    chk("out_vld",    32'(out_vld),    32'(e_vld));
    chk("out_data",   32'(out_data),   32'(e_data));
    chk("req_rdy",    32'(req_rdy),    32'(e_rdy));
    chk("grant",      32'(grant),      32'(e_grant));
    chk("busy",       32'(busy),       32'(e_busy));
    chk("forced_rel", 32'(forced_rel), 32'(m_forced));

    if (grant != '0 && prev_grant == '0)
      for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
    prev_grant = grant;
    if (forced_rel) forced_cnt++;
    if (out_vld && out_rdy) begin
      got_q.push_back(out_data);
      if (!(m_owner >= 0 && m_tag)) pay_q.push_back(out_data);
    end
    acc_mask = req_vld & req_rdy;

    if (rst) begin
      m_forced = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int w;
          w = (m_ptr + k) % N;
          if (!found && req_vld[w]) begin
            found   = 1'b1;
            m_owner = w;
            m_sent  = 0;
            m_tag   = TAG_EN;
          end
        end
      end else if (m_tag) begin
        if (out_rdy) m_tag = 1'b0;
      end else if (req_vld[m_owner] && out_rdy) begin
        m_sent++;
        if (req_last[m_owner] || m_sent == MAXB) begin
          m_forced = !req_last[m_owner];
          m_ptr    = (m_owner + 1) % N;
          m_owner  = -1;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i] && src_d[i].size() > 0) begin
        void'(src_d[i].pop_front());
        void'(src_l[i].pop_front());
      end
    end
    drive();
  endtask

  task automatic wait_idle(string name, int bound);
    bit done;
    done = 1'b0;
    for (int c = 0; c < bound && !done; c++) begin
      tick();
      done = src_empty() && (m_owner < 0);
    end
    chk({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic chk_stream(string name, int mark, bit use_got);
    int n;
    n = use_got ? (got_q.size() - mark) : (pay_q.size() - mark);
    chk({name, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < n; j++)
      chk(name, 32'(use_got ? got_q[mark+j] : pay_q[mark+j]), 32'(exp_q[j]));
  endtask

  task automatic do_reset();
    tick();
    #1 rst = 1'b0;
    clear_src();
    drive();
    tick();
    rst = 1'b1;
  endtask

  int mk_p, mk_g, mk_gl, mk_f, pushed, len;

  initial begin
    n_checks = 0; n_err = 0; forced_cnt = 0; prev_grant = '0; acc_mask = '0;
    m_owner = -1; m_ptr = 0; m_sent = 0; m_tag = 1'b0; m_forced = 1'b0;
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    rdy_drive = 1'b1;
    rst = 1'b0;
    drive();
    #2;
    chk("reset_grant",   32'(grant),      32'd0);
    chk("reset_busy",    32'(busy),       32'd0);
    chk("reset_out_vld", 32'(out_vld),    32'd0);
    chk("reset_req_rdy", 32'(req_rdy),    32'd0);
    chk("reset_forced",  32'(forced_rel), 32'd0);
    tick();
    tick();
    rst = 1'b1;

    // Round-robin fairness, 2-byte packets, all requesters valid.
    mk_p = pay_q.size(); mk_gl = grant_log.size();
    for (int r = 0; r < N; r++) begin
      push_byte(r, 8'(r*16 + 1), 1'b0);
      push_byte(r, 8'(r*16 + 2), 1'b1);
    end
    push_byte(0, 8'h03, 1'b0);
    push_byte(0, 8'h04, 1'b1);
    drive();
    wait_idle("rr", 200);
    exp_q = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h03, 8'h04};
    chk_stream("rr_stream", mk_p, 1'b0);
    chk("rr_grant_cnt", 32'(grant_log.size() - mk_gl), 32'd5);
    if (grant_log.size() - mk_gl == 5) begin
      chk("rr_order0", 32'(grant_log[mk_gl+0]), 32'd0);
      chk("rr_order1", 32'(grant_log[mk_gl+1]), 32'd1);
      chk("rr_order2", 32'(grant_log[mk_gl+2]), 32'd2);
      chk("rr_order3", 32'(grant_log[mk_gl+3]), 32'd3);
      chk("rr_order4", 32'(grant_log[mk_gl+4]), 32'd0);
    end

    // Backpressure on req2.
    mk_p = pay_q.size();
    push_byte(2, 8'h11, 1'b0);
    push_byte(2, 8'h22, 1'b0);
    push_byte(2, 8'h33, 1'b1);
    begin
      logic pat[6];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int j = 0; j < 6; j++) begin
        rdy_drive = pat[j];
        drive();
        tick();
      end
    end
    rdy_drive = 1'b1;
    drive();
    wait_idle("bp", 100);
    exp_q = '{8'h11, 8'h22, 8'h33};
    chk_stream("bp_stream", mk_p, 1'b0);

    // Burst limit: req0 ten bytes (last only on the tenth), req1 waiting.
    do_reset();
    mk_p = pay_q.size(); mk_gl = grant_log.size(); mk_f = forced_cnt;
    for (int j = 0; j < 10; j++) push_byte(0, 8'(8'hB0 + j), j == 9);
    push_byte(1, 8'hC1, 1'b1);
    drive();
    wait_idle("burst", 200);
    exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC1, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9};
    chk_stream("burst_stream", mk_p, 1'b0);
    chk("burst_forced_cnt", 32'(forced_cnt - mk_f), 32'd2);
    chk("burst_grant_cnt", 32'(grant_log.size() - mk_gl), 32'd4);
    if (grant_log.size() - mk_gl >= 2)
      chk("burst_second_owner", 32'(grant_log[mk_gl+1]), 32'd1);

    // Last byte coincides with the limit.
    mk_p = pay_q.size(); mk_f = forced_cnt;
    for (int j = 0; j < 4; j++) push_byte(0, 8'(8'hD0 + j), j == 3);
    drive();
    wait_idle("coinc", 100);
    exp_q = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    chk_stream("coinc_stream", mk_p, 1'b0);
    chk("coinc_forced_cnt", 32'(forced_cnt - mk_f), 32'd0);

    // Tag byte (present only when the feature is built in).
    mk_g = got_q.size();
    push_byte(3, 8'h5A, 1'b1);
    drive();
    wait_idle("tag", 100);
    if (TAG_EN) exp_q = '{8'hA3, 8'h5A};
    else        exp_q = '{8'h5A};
    chk_stream("tag_stream", mk_g, 1'b1);

    // Reset mid-packet: req1 has sent 3 of 5 bytes.
    do_reset();
    mk_p = pay_q.size();
    for (int j = 0; j < 5; j++) push_byte(1, 8'(8'hE0 + j), j == 4);
    drive();
    for (int c = 0; c < 50 && (pay_q.size() - mk_p) < 3; c++) tick();
    chk("rstmid_sent", 32'(pay_q.size() - mk_p), 32'd3);
    chk("rstmid_grant_before", 32'(grant), 32'h2);
    #1 rst = 1'b0;
    #1;
    chk("rstmid_grant",    32'(grant),      32'd0);
    chk("rstmid_busy",     32'(busy),       32'd0);
    chk("rstmid_out_vld",  32'(out_vld),    32'd0);
    chk("rstmid_out_data", 32'(out_data),   32'd0);
    chk("rstmid_req_rdy",  32'(req_rdy),    32'd0);
    chk("rstmid_forced",   32'(forced_rel), 32'd0);
    clear_src();
    drive();
    tick();
    rst = 1'b1;
    mk_p = pay_q.size(); mk_gl = grant_log.size();
    push_byte(1, 8'hF1, 1'b1);
    push_byte(0, 8'hF0, 1'b1);
    drive();
    wait_idle("rstmid_after", 100);
    exp_q = '{8'hF0, 8'hF1};
    chk_stream("rstmid_stream", mk_p, 1'b0);
    if (grant_log.size() > mk_gl)
      chk("rstmid_first_owner", 32'(grant_log[mk_gl]), 32'd0);
    else
      chk("rstmid_first_owner_seen", 32'd0, 32'd1);

    // Randomized traffic with random stalls and backpressure.
    mk_g = got_q.size(); mk_gl = grant_log.size();
    pushed = 0;
    for (int p = 0; p < 30; p++) begin
      int r;
      r   = $urandom_range(0, N-1);
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) push_byte(r, 8'($urandom_range(0, 255)), j == len-1);
      pushed += len;
    end
    drive();
    for (int c = 0; c < 3000 && !(src_empty() && m_owner < 0); c++) begin
      rdy_drive = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 4) != 0);
      tick();
    end
    rdy_drive = 1'b1;
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    drive();
    wait_idle("rand", 500);
    chk("rand_bytes", 32'(got_q.size() - mk_g),
        32'(pushed + (TAG_EN ? (grant_log.size() - mk_gl) : 0)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
